// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit for the EX stage, producing the HI/LO pair.
// Shift-add multiply and restoring divide, one bit per stepped cycle, sign-fixed afterwards.
module ex_muldiv_unit #(
  parameter int BITS_SIZE = 32
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_step,
  input  logic                 i_flush,
  input  logic                 i_start,
  input  logic [1:0]           i_op,
  input  logic [BITS_SIZE-1:0] i_operand_a,
  input  logic [BITS_SIZE-1:0] i_operand_b,
  input  logic                 i_mthi,
  input  logic                 i_mtlo,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [BITS_SIZE-1:0] o_hi,
  output logic [BITS_SIZE-1:0] o_lo
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_MUL  = 3'd1;
  localparam logic [2:0] ST_DIV  = 3'd2;
  localparam logic [2:0] ST_FIX  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  localparam logic [5:0] LAST_ITER = 6'(BITS_SIZE - 1);

  logic [2:0]             r_state;
  logic [5:0]             r_count;
  logic                   r_isDiv;
  logic                   r_divZero;
  logic                   r_negRes;
  logic                   r_negRem;
  logic [BITS_SIZE-1:0]   r_opnd;
  logic [2*BITS_SIZE-1:0] r_acc;
  logic [BITS_SIZE-1:0]   r_rem;
  logic [BITS_SIZE-1:0]   r_quo;
  logic [BITS_SIZE-1:0]   r_hi;
  logic [BITS_SIZE-1:0]   r_lo;
  logic                   r_busy;
  logic                   r_done;

  logic                 w_signedOp;
  logic                 w_aNeg;
  logic                 w_bNeg;
  logic [BITS_SIZE-1:0] w_aMag;
  logic [BITS_SIZE-1:0] w_bMag;
  logic [BITS_SIZE:0]   w_mulSum;
  logic [BITS_SIZE:0]   w_divShift;
  logic [BITS_SIZE:0]   w_divDiff;
  logic                 w_divFits;
  logic                 w_lastIter;

  assign w_signedOp = ~i_op[0];
  assign w_aNeg     = w_signedOp & i_operand_a[BITS_SIZE-1];
  assign w_bNeg     = w_signedOp & i_operand_b[BITS_SIZE-1];
  assign w_aMag     = w_aNeg ? -i_operand_a : i_operand_a;
  assign w_bMag     = w_bNeg ? -i_operand_b : i_operand_b;

  // Multiplier sits in the low half of the accumulator and is consumed LSB first.
  assign w_mulSum   = {1'b0, r_acc[2*BITS_SIZE-1:BITS_SIZE]}
                    + {1'b0, (r_acc[0] ? r_opnd : {BITS_SIZE{1'b0}})};

  // The partial remainder is always below 2*divisor, so the difference MSB is the borrow.
  assign w_divShift = {r_rem, r_quo[BITS_SIZE-1]};
  assign w_divDiff  = w_divShift - {1'b0, r_opnd};
  assign w_divFits  = ~w_divDiff[BITS_SIZE];
  assign w_lastIter = (r_count == LAST_ITER);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state   <= ST_IDLE;
      r_count   <= '0;
      r_isDiv   <= 1'b0;
      r_divZero <= 1'b0;
      r_negRes  <= 1'b0;
      r_negRem  <= 1'b0;
      r_opnd    <= '0;
      r_acc     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else if (i_flush) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (i_step) begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_isDiv   <= i_op[1];
            r_negRes  <= w_aNeg ^ w_bNeg;
            r_negRem  <= w_aNeg;
            r_divZero <= i_op[1] && (i_operand_b == '0);
            r_count   <= '0;
            r_busy    <= 1'b1;
            if (!i_op[1]) begin
              r_opnd  <= w_aMag;
              r_acc   <= {{BITS_SIZE{1'b0}}, w_bMag};
              r_state <= ST_MUL;
            end else if (i_operand_b == '0) begin
              r_rem   <= i_operand_a;
              r_quo   <= '1;
              r_state <= ST_FIX;
            end else begin
              r_opnd  <= w_bMag;
              r_quo   <= w_aMag;
              r_rem   <= '0;
              r_state <= ST_DIV;
            end
          end else begin
            if (i_mthi) r_hi <= i_operand_a;
            if (i_mtlo) r_lo <= i_operand_a;
          end
        end
        ST_MUL: begin
          r_acc   <= {w_mulSum, r_acc[BITS_SIZE-1:1]};
          r_count <= r_count + 6'd1;
          if (w_lastIter) r_state <= ST_FIX;
        end
        ST_DIV: begin
          r_rem   <= w_divFits ? w_divDiff[BITS_SIZE-1:0] : w_divShift[BITS_SIZE-1:0];
          r_quo   <= {r_quo[BITS_SIZE-2:0], w_divFits};
          r_count <= r_count + 6'd1;
          if (w_lastIter) r_state <= ST_FIX;
        end
        ST_FIX: begin
          // Unsigned ops never set the sign flags; divide-by-zero keeps its raw result.
          if (r_isDiv) begin
            if (!r_divZero) begin
              if (r_negRes) r_quo <= -r_quo;
              if (r_negRem) r_rem <= -r_rem;
            end
          end else if (r_negRes) begin
            r_acc <= -r_acc;
          end
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          if (r_isDiv) begin
            r_hi <= r_rem;
            r_lo <= r_quo;
          end else begin
            r_hi <= r_acc[2*BITS_SIZE-1:BITS_SIZE];
            r_lo <= r_acc[BITS_SIZE-1:0];
          end
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Iterative multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register. It consumes the register-read operands and the decoded mult/div operation latched by ID/EX, and computes MULT/MULTU/DIV/DIVU over multiple cycles into architectural HI/LO registers. While an operation is in flight it raises a busy flag; the hazard unit uses that flag to stall dependent MFHI/MFLO/MTHI/MTLO instructions and further mult/div issues. Progress is gated by the same pipeline step enable used by the pipeline registers, so debug single-stepping advances it one iteration per step.

## Interface
- BITS_SIZE, 32, operand/HI/LO width
- i_clk  in  1  clock, all state on rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_step  in  1  pipeline advance enable; state changes only on edges where i_step=1 (reset and flush excepted)
- i_flush  in  1  abort in-flight operation (branch/exception squash)
- i_start  in  1  issue the operation selected by i_op
- i_op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- i_operand_a  in  BITS_SIZE  rs data (multiplicand / dividend)
- i_operand_b  in  BITS_SIZE  rt data (multiplier / divisor)
- i_mthi  in  1  write i_operand_a into HI
- i_mtlo  in  1  write i_operand_a into LO
- o_busy  out  1  operation in flight; HI/LO not yet valid
- o_done  out  1  one-cycle pulse on the cycle HI/LO are updated by an operation
- o_hi  out  BITS_SIZE  HI register
- o_lo  out  BITS_SIZE  LO register

## Operation
- FSM states: IDLE, MUL, DIV, FIX, DONE.
- IDLE: on i_step&&i_start, latch operation, compute magnitudes (signed ops: two's-complement absolute value of each operand; unsigned ops: raw), record result signs, clear 6-bit iteration counter, go to MUL (op[1]=0) or DIV (op[1]=1).
- MUL: shift-add, one multiplier bit per step cycle into a 2*BITS_SIZE accumulator; after BITS_SIZE iterations go to FIX.
- DIV: restoring division, one quotient bit per step cycle, BITS_SIZE+1-bit partial remainder; after BITS_SIZE iterations go to FIX.
- FIX: signed ops apply sign correction. Product negated (64-bit) when operand signs differ. Quotient negated when signs differ; remainder takes the dividend's sign. Then go to DONE.
- DONE: write HI/LO (MUL: HI=product[63:32], LO=product[31:0]; DIV: HI=remainder, LO=quotient), pulse o_done, return to IDLE.
- Divide by zero (b=0, DIV or DIVU): HI=i_operand_a as latched, LO=all ones. Skip iterations: DIV→FIX→DONE still applies, with no sign fix on this result.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. This falls out of the magnitude method; no special case is needed.
- MTHI/MTLO: honoured only in IDLE with i_step=1; both may be set together. Ignored while busy. If i_start and i_mthi/i_mtlo are set together, start wins and the moves are ignored.
- i_start while not IDLE: ignored.
- i_flush: next edge forces IDLE, counter 0, o_busy=0, o_done=0; HI/LO keep prior values. Takes precedence over i_step and i_start.
- Async reset (i_reset=0): state IDLE, counter 0, HI=0, LO=0, o_busy=0, o_done=0. Valid at any point, including mid-operation.

## Timing
- o_busy is registered: 1 from the edge accepting i_start until the edge that enters DONE's successor. It is high in MUL/DIV/FIX/DONE and low in IDLE.
- Latency in step cycles from the accepting edge: BITS_SIZE iterations + 1 FIX + 1 DONE = 34. HI/LO are visible and o_done=1 in the cycle after the 34th stepped edge.
- Divide by zero: 2 step cycles (FIX, DONE).
- Cycles with i_step=0 freeze all state; o_done holds its value through the freeze.
- MTHI/MTLO: HI/LO visible one cycle after the accepting edge; no o_done pulse.
- Back-to-back operations: a new i_start is accepted the cycle o_busy falls; no bubble beyond that.

## Test plan
- Reset, then MULT a=0xFFFFFFFE b=0x00000003, i_step=1 always -> o_busy high 34 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA, o_done one-cycle pulse.
- MULTU a=b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU a=0x64, b=0 -> HI=0x64, LO=0xFFFFFFFF after 2 step cycles.
- DIVU 100/7 with i_step toggling 1,0 each cycle -> result LO=14, HI=2 after exactly 34 stepped edges (68 clocks). i_mthi pulsed mid-op is ignored; MTHI 0x1234 in IDLE -> HI=0x1234.
- MULT 5*6 with i_flush at iteration 10 -> IDLE next cycle, o_busy=0, HI/LO unchanged, no o_done. Repeat with i_reset=0 at iteration 10 -> HI=LO=0 immediately.
